// File: rtl/g06_sha256_avalon_slave_if.sv
// -----------------------------------------------------------------------------
// g06_sha256_avalon_slave_if
// Avalon-MM bus bundle between the HPS lightweight-bridge master and the
// SHA-256 register slave. Fixed read latency of one cycle, no waitrequest.
//   avs_address        word address (ADDR_W bits), master -> slave
//   avs_read           read strobe, master -> slave
//   avs_write          write strobe, master -> slave
//   avs_writedata      32-bit write data, master -> slave
//   avs_readdata       32-bit read data, slave -> master
//   avs_readdatavalid  read response strobe, slave -> master
// -----------------------------------------------------------------------------
interface g06_sha256_avalon_slave_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/g06_sha256_avalon_slave.sv
// -----------------------------------------------------------------------------
// g06_sha256_avalon_slave
// Register front end for the SHA-256 core: buffers one 512-bit block written by
// software, launches the core, waits for completion (with timeout), latches the
// digest and reports status / digest / completed-block count.
// Ports:
//   clk_clk, reset_reset_n  clock and asynchronous active-low reset
//   avs                     Avalon-MM slave bundle (g06_sha256_avalon_slave_if)
//   core_start/core_init    one-cycle launch pulse and IV-vs-chain select
//   core_block              message buffer, W0 in [511:480] .. W15 in [31:0]
//   core_done/core_digest   completion pulse and digest H0..H7
//   irq                     interrupt (only when G06_SHA_IRQ_EN is defined)
// Optional feature macro: G06_SHA_IRQ_EN (adds irq port and CTRL bit2 IRQEN).
// -----------------------------------------------------------------------------
module g06_sha256_avalon_slave #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  g06_sha256_avalon_slave_if.slave  avs,
  output logic                      core_start,
  output logic                      core_init,
  output logic [511:0]              core_block,
  input  logic                      core_done,
  input  logic [255:0]              core_digest
`ifdef G06_SHA_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(5'h10);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5'h11);
  localparam logic [ADDR_W-1:0] A_BLKCNT = ADDR_W'(5'h12);
  localparam logic [ADDR_W-1:0] A_H0     = ADDR_W'(5'h18);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_w [16];
  logic [31:0]        r_h [8];
  logic               r_done;
  logic               r_err;
  logic               r_to;
  logic [31:0]        r_blkcnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_core_start;
  logic               r_core_init;
  logic [31:0]        r_rdata;
  logic               r_rvalid;
`ifdef G06_SHA_IRQ_EN
  logic               r_irqen;
  logic               r_irq;
`endif

  logic [ADDR_W-1:0]  w_addr;
  logic [31:0]        w_wdata;
  logic               w_wr;
  logic               w_rd;
  logic               w_busy;
  logic               w_is_w;
  logic               w_is_h;
  logic               w_ctrl_wr;
  logic               w_stat_wr;
  logic               w_blk_wr;
  logic               w_start_req;
  logic               w_launch;
  logic               w_done_set;
  logic               w_to_set;
  logic               w_err_set;
  logic [31:0]        w_rd_mux;

  assign w_addr      = avs.avs_address;
  assign w_wdata     = avs.avs_writedata;
  assign w_wr        = avs.avs_write;
  // A read colliding with a write is dropped entirely (no response).
  assign w_rd        = avs.avs_read & ~avs.avs_write;
  assign w_busy      = (r_state != S_IDLE);
  assign w_is_w      = (w_addr[ADDR_W-1:4] == '0);
  assign w_is_h      = (w_addr[ADDR_W-1:3] == A_H0[ADDR_W-1:3]);
  assign w_ctrl_wr   = w_wr & (w_addr == A_CTRL);
  assign w_stat_wr   = w_wr & (w_addr == A_STATUS);
  assign w_blk_wr    = w_wr & (w_addr == A_BLKCNT);
  assign w_start_req = w_ctrl_wr & w_wdata[0];
  assign w_err_set   = (w_wr & w_is_w & w_busy) | (w_start_req & w_busy) | w_to_set;

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_next_state;
  end

  // FSM next-state and event decode; completion beats timeout in the same cycle
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_done_set   = 1'b0;
    w_to_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          w_next_state = S_LAUNCH;
          w_launch     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LAUNCH: w_next_state = S_RUN;
      S_RUN: begin
        if (core_done) begin
          w_next_state = S_IDLE;
          w_done_set   = 1'b1;
        end else if (r_cnt == TO_VAL) begin
          w_next_state = S_IDLE;
          w_to_set     = 1'b1;
        end else begin
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Sticky status bits: a same-cycle set overrides the write-1-to-clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_done <= w_done_set | (r_done & ~(w_stat_wr & w_wdata[1]) & ~w_launch);
      r_err  <= w_err_set  | (r_err  & ~(w_stat_wr & w_wdata[2]));
      r_to   <= w_to_set   | (r_to   & ~(w_stat_wr & w_wdata[3]));
    end
  end

  // Completed-block counter; a write always wins, so write+increment gives 0
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  r_blkcnt <= 32'h0;
    else if (w_blk_wr)   r_blkcnt <= 32'h0;
    else if (w_done_set) r_blkcnt <= r_blkcnt + 32'd1;
  end

  // Run-time counter: cleared entering LAUNCH, saturates at the timeout value
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                 r_cnt <= '0;
    else if (w_launch)                  r_cnt <= '0;
    else if (w_busy && r_cnt != TO_VAL) r_cnt <= r_cnt + 1'b1;
  end

  // Launch pulse, aligned with the LAUNCH state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_core_start <= 1'b0;
      r_core_init  <= 1'b0;
    end else begin
      r_core_start <= w_launch;
      r_core_init  <= w_launch & w_wdata[1];
    end
  end

  // Message buffer; frozen while the core is busy
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= 32'h0;
    end else if (w_wr && w_is_w && !w_busy) begin
      r_w[w_addr[3:0]] <= w_wdata;
    end
  end

  // Digest capture on core completion only
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 8; i++) r_h[i] <= 32'h0;
    end else if (w_done_set) begin
      for (int i = 0; i < 8; i++) r_h[i] <= core_digest[224 - 32*i +: 32];
    end
  end

  // Read-data multiplexer
  always_comb begin
    w_rd_mux = 32'h0;
    if (w_is_w) begin
      w_rd_mux = r_w[w_addr[3:0]];
    end else if (w_is_h) begin
      w_rd_mux = r_h[w_addr[2:0]];
    end else if (w_addr == A_STATUS) begin
      w_rd_mux = {28'h0, r_to, r_err, r_done, w_busy};
    end else if (w_addr == A_BLKCNT) begin
      w_rd_mux = r_blkcnt;
`ifdef G06_SHA_IRQ_EN
    end else if (w_addr == A_CTRL) begin
      w_rd_mux = {29'h0, r_irqen, 2'b00};
`endif
    end else begin
      w_rd_mux = 32'h0;
    end
  end

  // Read response, one cycle latency; data forced to 0 when not valid
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rd_mux : 32'h0;
    end
  end

`ifdef G06_SHA_IRQ_EN
  // Interrupt enable latch and registered interrupt
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irqen <= w_wdata[2];
      r_irq <= r_irqen & (r_done | r_to);
    end
  end

  assign irq = r_irq;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_block
    assign core_block[480 - 32*g +: 32] = r_w[g];
  end

  assign core_start            = r_core_start;
  assign core_init             = r_core_init;
  assign avs.avs_readdata      = r_rdata;
  assign avs.avs_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_g06_sha256_avalon_slave.sv
// -----------------------------------------------------------------------------
// tb_g06_sha256_avalon_slave
// Directed self-checking bench for the SHA-256 Avalon slave. The DUT runs with
// TIMEOUT=15 so the timeout path is reachable quickly. Bus tasks are entered
// right after a falling edge; each bus beat occupies one clock.
// -----------------------------------------------------------------------------
module tb_g06_sha256_avalon_slave;
  localparam int ADDR_W = 5;

  localparam logic [4:0] A_CTRL   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h11;
  localparam logic [4:0] A_BLKCNT = 5'h12;
  localparam logic [4:0] A_H0     = 5'h18;
  localparam logic [4:0] A_H1     = 5'h19;
  localparam logic [4:0] A_H7     = 5'h1F;

  localparam logic [255:0] DG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DG_ALT = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};

  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic         core_start;
  logic         core_init;
  logic [511:0] core_block;
  logic         core_done;
  logic [255:0] core_digest;
`ifdef G06_SHA_IRQ_EN
  logic         irq;
`endif

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   start_cnt = 0;
  logic last_init = 1'b0;

  g06_sha256_avalon_slave_if #(.ADDR_W(ADDR_W)) avs_bus ();

  g06_sha256_avalon_slave #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (avs_bus),
    .core_start    (core_start),
    .core_init     (core_init),
    .core_block    (core_block),
    .core_done     (core_done),
    .core_digest   (core_digest)
`ifdef G06_SHA_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  // Count launch pulses seen by the core side
  always @(negedge clk_clk) begin
    if (core_start) begin
      start_cnt = start_cnt + 1;
      last_init = core_init;
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs_bus.avs_address   = a;
    avs_bus.avs_writedata = d;
    avs_bus.avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
    avs_bus.avs_address = a;
    avs_bus.avs_read    = 1'b1;
    @(negedge clk_clk);
    avs_bus.avs_read    = 1'b0;
    d = avs_bus.avs_readdata;
    v = avs_bus.avs_readdatavalid;
  endtask

  task automatic pulse_done(input logic [255:0] dg);
    core_done   = 1'b1;
    core_digest = dg;
    @(negedge clk_clk);
    core_done   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    reset_reset_n = 1'b0;
    repeat (2) @(negedge clk_clk);
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    n_checks++; if (core_init !== 1'b0) begin n_fail++; $display("FAIL reset_core_init got=%b exp=0", core_init); end
    n_checks++; if (core_block !== 512'h0) begin n_fail++; $display("FAIL reset_core_block got=%h exp=0", core_block); end
    n_checks++; if (avs_bus.avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", avs_bus.avs_readdatavalid); end
    n_checks++; if (avs_bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", avs_bus.avs_readdata); end
`ifdef G06_SHA_IRQ_EN
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL reset_status got=%h/%b exp=00000000/1", d, v); end
    bus_read(A_H0, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_h0 got=%h exp=00000000", d); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_blkcnt got=%h exp=00000000", d); end
  endtask

  task automatic test_abc();
    logic [31:0] d;
    logic        v;
    int          s0;
    for (int i = 0; i < 16; i++) begin
      bus_write(5'(i), (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0));
    end
    n_checks++; if (core_block !== BLK_ABC) begin n_fail++; $display("FAIL abc_block got=%h exp=%h", core_block, BLK_ABC); end
    s0 = start_cnt;
    bus_write(A_CTRL, 32'h3);
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL abc_busy got=%h exp=00000001", d); end
    pulse_done(DG_ABC);
    @(negedge clk_clk);
    n_checks++; if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL abc_start_count got=%0d exp=%0d", start_cnt, s0 + 1); end
    n_checks++; if (last_init !== 1'b1) begin n_fail++; $display("FAIL abc_init got=%b exp=1", last_init); end
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL abc_status got=%h exp=00000002", d); end
    bus_read(A_H0, d, v);
    n_checks++; if (d !== 32'hBA7816BF) begin n_fail++; $display("FAIL abc_h0 got=%h exp=ba7816bf", d); end
    bus_read(A_H7, d, v);
    n_checks++; if (d !== 32'hF20015AD) begin n_fail++; $display("FAIL abc_h7 got=%h exp=f20015ad", d); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL abc_blkcnt got=%h exp=00000001", d); end
    bus_read(A_CTRL, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL abc_ctrl_read got=%h exp=00000000", d); end
    bus_read(5'h00, d, v);
    n_checks++; if (d !== 32'h61626380) begin n_fail++; $display("FAIL abc_w0_read got=%h exp=61626380", d); end
  endtask

  task automatic test_busy();
    logic [31:0] d;
    logic        v;
    int          s0;
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL busy_w1c got=%h exp=00000000", d); end
    s0 = start_cnt;
    bus_write(A_CTRL, 32'h1);
    bus_write(5'h03, 32'hDEADBEEF);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL busy_status got=%h exp=00000005", d); end
    n_checks++; if (core_block !== BLK_ABC) begin n_fail++; $display("FAIL busy_block got=%h exp=%h", core_block, BLK_ABC); end
    pulse_done(DG_ALT);
    @(negedge clk_clk);
    n_checks++; if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL busy_start_count got=%0d exp=%0d", start_cnt, s0 + 1); end
    n_checks++; if (last_init !== 1'b0) begin n_fail++; $display("FAIL busy_chain_init got=%b exp=0", last_init); end
    bus_read(5'h03, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL busy_w3 got=%h exp=00000000", d); end
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h6) begin n_fail++; $display("FAIL busy_status_after got=%h exp=00000006", d); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL busy_blkcnt got=%h exp=00000002", d); end
    bus_read(A_H0, d, v);
    n_checks++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL busy_h0 got=%h exp=11111111", d); end
    bus_write(A_STATUS, 32'h6);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic [31:0] idle_data;
    logic        v;
    int          idle_at;
    idle_at   = -1;
    idle_data = 32'h0;
    bus_write(A_CTRL, 32'h1);
    // Read i samples the bus i+1 cycles after the launch edge
    for (int i = 0; i < 20; i++) begin
      bus_read(A_STATUS, d, v);
      if (idle_at < 0 && d[0] == 1'b0) begin
        idle_at   = i;
        idle_data = d;
      end
    end
    n_checks++; if (idle_at !== 16) begin n_fail++; $display("FAIL timeout_idle_read_index got=%0d exp=16", idle_at); end
    n_checks++; if (idle_data !== 32'hC) begin n_fail++; $display("FAIL timeout_status got=%h exp=0000000c", idle_data); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL timeout_blkcnt got=%h exp=00000002", d); end
    bus_read(A_H0, d, v);
    n_checks++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL timeout_h0 got=%h exp=11111111", d); end
    bus_write(A_STATUS, 32'hC);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    logic        v;
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clk_clk);
    core_done             = 1'b1;
    core_digest           = DG_ABC;
    avs_bus.avs_address   = A_STATUS;
    avs_bus.avs_writedata = 32'h2;
    avs_bus.avs_write     = 1'b1;
    @(negedge clk_clk);
    core_done             = 1'b0;
    avs_bus.avs_write     = 1'b0;
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL race_status got=%h exp=00000002", d); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL race_blkcnt got=%h exp=00000003", d); end
    avs_bus.avs_address = A_H0;
    avs_bus.avs_read    = 1'b1;
    @(negedge clk_clk);
    n_checks++; if (avs_bus.avs_readdatavalid !== 1'b1 || avs_bus.avs_readdata !== 32'hBA7816BF) begin
      n_fail++; $display("FAIL b2b_first got=%h/%b exp=ba7816bf/1", avs_bus.avs_readdata, avs_bus.avs_readdatavalid); end
    avs_bus.avs_address = A_H1;
    @(negedge clk_clk);
    n_checks++; if (avs_bus.avs_readdatavalid !== 1'b1 || avs_bus.avs_readdata !== 32'h8F01CFEA) begin
      n_fail++; $display("FAIL b2b_second got=%h/%b exp=8f01cfea/1", avs_bus.avs_readdata, avs_bus.avs_readdatavalid); end
    avs_bus.avs_read = 1'b0;
    @(negedge clk_clk);
    n_checks++; if (avs_bus.avs_readdatavalid !== 1'b0 || avs_bus.avs_readdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_idle got=%h/%b exp=00000000/0", avs_bus.avs_readdata, avs_bus.avs_readdatavalid); end
    avs_bus.avs_address   = A_BLKCNT;
    avs_bus.avs_writedata = 32'h55;
    avs_bus.avs_read      = 1'b1;
    avs_bus.avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_bus.avs_read      = 1'b0;
    avs_bus.avs_write     = 1'b0;
    n_checks++; if (avs_bus.avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rw_collision_rvalid got=%b exp=0", avs_bus.avs_readdatavalid); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rw_collision_blkcnt got=%h exp=00000000", d); end
    bus_write(A_STATUS, 32'h2);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic        v;
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    pulse_done(DG_ALT);
    bus_read(A_STATUS, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_status got=%h exp=00000000", d); end
    bus_read(A_BLKCNT, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_blkcnt got=%h exp=00000000", d); end
    bus_read(A_H0, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_h0 got=%h exp=00000000", d); end
    n_checks++; if (core_block !== 512'h0) begin n_fail++; $display("FAIL midrun_block got=%h exp=0", core_block); end
  endtask

`ifdef G06_SHA_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    logic        v;
    bus_write(A_CTRL, 32'h7);
    @(negedge clk_clk);
    pulse_done(DG_ABC);
    @(negedge clk_clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got=%b exp=1", irq); end
    bus_read(A_CTRL, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL irq_ctrl_read got=%h exp=00000004", d); end
    bus_write(A_STATUS, 32'h2);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got=%b exp=1", irq); end
    @(negedge clk_clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b exp=0", irq); end
  endtask
`endif

  initial begin
    avs_bus.avs_address   = 5'h0;
    avs_bus.avs_read      = 1'b0;
    avs_bus.avs_write     = 1'b0;
    avs_bus.avs_writedata = 32'h0;
    core_done             = 1'b0;
    core_digest           = 256'h0;
    reset_reset_n         = 1'b0;
    @(negedge clk_clk);
    test_reset();
    test_abc();
    test_busy();
    test_timeout();
    test_w1c_race();
    test_reset_mid_run();
`ifdef G06_SHA_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
